// File: rtl/legv8_imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : legv8_imm_encoder
//  Purpose  : Two-stage LEGv8 instruction encoder (B / CBZ / LDUR / STUR).
//             Range-checks a 64-bit signed immediate against the field width
//             of the selected class and packs it into a 32-bit word. Out of
//             range immediates produce out_err=1 with a zero word. Counts
//             delivered good and rejected words.
//  Revision : 1.0 - initial release
// ============================================================================
module legv8_imm_encoder #(
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_fmt,
  input  logic [63:0]      in_imm,
  input  logic [4:0]       in_rn,
  input  logic [4:0]       in_rt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [1:0] FMT_B    = 2'd0;
  localparam logic [1:0] FMT_CBZ  = 2'd1;
  localparam logic [1:0] FMT_LDUR = 2'd2;
  localparam logic [1:0] FMT_STUR = 2'd3;

  // Stage 1 holding registers
  logic        s1_valid;
  logic [1:0]  s1_fmt;
  logic [63:0] s1_imm;
  logic [4:0]  s1_rn;
  logic [4:0]  s1_rt;

  logic        s2_adv;
  logic        s1_adv;
  logic        legal;
  logic [31:0] packed_word;
  logic        handshake;

  // S2 moves when it is empty or its word is being taken; S1 moves when it is
  // empty or S2 moves. in_ready deliberately ignores in_valid.
  assign s2_adv    = !out_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign handshake = out_valid && out_ready;

  // Range check: bits [63:N-1] must all equal the sign bit
  always_comb begin
    legal = 1'b0;
    case (s1_fmt)
      FMT_B:   legal = (&s1_imm[63:25]) | ~(|s1_imm[63:25]);
      FMT_CBZ: legal = (&s1_imm[63:18]) | ~(|s1_imm[63:18]);
      default: legal = (&s1_imm[63:8])  | ~(|s1_imm[63:8]);
    endcase
  end

  // Field packing for each instruction class
  always_comb begin
    packed_word = 32'h0;
    case (s1_fmt)
      FMT_B:    packed_word = {6'b000101, s1_imm[25:0]};
      FMT_CBZ:  packed_word = {8'b10110100, s1_imm[18:0], s1_rt};
      FMT_LDUR: packed_word = {11'b11111000010, s1_imm[8:0], 2'b00, s1_rn, s1_rt};
      FMT_STUR: packed_word = {11'b11111000000, s1_imm[8:0], 2'b00, s1_rn, s1_rt};
      default:  packed_word = 32'h0;
    endcase
  end

  // Stage 1: capture the request payload on an accepting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_fmt   <= 2'd0;
      s1_imm   <= 64'd0;
      s1_rn    <= 5'd0;
      s1_rt    <= 5'd0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_fmt <= in_fmt;
        s1_imm <= in_imm;
        s1_rn  <= in_rn;
        s1_rt  <= in_rt;
      end
    end
  end

  // Stage 2: register the encoded word; an illegal immediate yields a zero word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      out_instr <= 32'h0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      out_err   <= s1_valid && !legal;
      out_instr <= (s1_valid && legal) ? packed_word : 32'h0;
    end
  end

  // Delivery counters: good words wrap, rejected words saturate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (handshake) begin
      if (!out_err) begin
        enc_count <= enc_count + CNT_W'(1);
      end else if (err_count != {ERR_W{1'b1}}) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/legv8_imm_encoder.md
# legv8_imm_encoder

Pipelined LEGv8 instruction encoder for the ARM_CPU test and boot infrastructure. It accepts an instruction class, register fields and a 64-bit signed immediate. It range-checks the immediate against the class's field width and packs it into a 32-bit instruction word, the inverse of the core's immediate sign-extension stage. It feeds the instruction-memory loader and the self-check bench through a valid/ready stream, and keeps counts of encoded and rejected words.

## Interface
- CNT_W, 16, width of the encoded-word counter
- ERR_W, 8, width of the saturating reject counter
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  encoder can accept a request this cycle
- in_fmt  input  2  class: 0=B, 1=CBZ, 2=LDUR, 3=STUR
- in_imm  input  64  signed immediate (two's complement)
- in_rn  input  5  base register (LDUR/STUR only)
- in_rt  input  5  target register (CBZ/LDUR/STUR)
- out_valid  output  1  encoded word valid
- out_ready  input  1  consumer accepts word
- out_instr  output  32  encoded instruction
- out_err  output  1  immediate out of range; out_instr forced to 0
- enc_count  output  CNT_W  words delivered with out_err=0, wraps
- err_count  output  ERR_W  words delivered with out_err=1, saturates at all-ones

## Operation
- Field widths N: B=26, CBZ=19, LDUR/STUR=9.
- Range rule: in_imm is legal iff in_imm[63:N-1] are all equal (value in [-2^(N-1), 2^(N-1)-1]).
- Packing:
  - B: {6'b000101, imm[25:0]}
  - CBZ: {8'b10110100, imm[18:0], rt}
  - LDUR: {11'b11111000010, imm[8:0], 2'b00, rn, rt}
  - STUR: {11'b11111000000, imm[8:0], 2'b00, rn, rt}
- Unused register inputs are ignored.
- Round-trip property: for a legal input, sign-extending the packed immediate field of out_instr to 64 bits reproduces in_imm exactly.
- Illegal immediate: out_err=1 and out_instr=32'h0. The word still occupies one pipeline slot and one handshake. It is never silently truncated.
- Pipeline:
  - Stage 1 (S1) registers fmt/imm/rn/rt and computes the range check.
  - Stage 2 (S2) registers out_instr/out_err/out_valid.
- Stall logic:
  - S2 advances when !out_valid || out_ready.
  - S1 advances when S1 is empty or S2 advances.
  - in_ready equals the S1 advance condition (combinational, no dependence on in_valid).
- Counters update only on an output handshake (out_valid && out_ready):
  - enc_count increments by 1 when out_err=0 and wraps modulo 2^CNT_W.
  - err_count increments by 1 when out_err=1 and holds at 2^ERR_W-1.

## Timing
- Reset (asynchronous, takes effect while rst_n=0):
  - S1 valid, out_valid, out_err, out_instr, enc_count and err_count all go to 0.
  - in_ready=1 from the first cycle after release.
- Latency: a request accepted at edge k appears with out_valid=1 after edge k+1 when there is no backpressure (2 register stages).
- Throughput: one word per cycle while out_ready=1 continuously.
- Backpressure with out_ready=0 and out_valid=1:
  - out_instr and out_err hold stable.
  - S1 accepts at most one more request, then in_ready=0.
  - When out_ready returns, order is preserved and nothing is lost or duplicated.
- Simultaneous events: while both stages are full, a cycle with out_ready=1 and in_valid=1 delivers one word and accepts one request on the same edge.
- in_valid may drop at any time and the producer may change the payload while in_ready=0. Only values present at an accepting edge are captured.
- Reset mid-operation discards in-flight words. Counters do not count discarded words.

## Test plan
- Reset, then B with imm=-4 and out_ready=1 -> out_valid=1 two edges after accept, out_instr=32'h17FFFFFC, out_err=0, enc_count=1.
- CBZ imm=3, rt=9; LDUR imm=-1, rn=2, rt=1; STUR imm=255, rn=31, rt=0 -> out_instr=32'hB4000069, 32'hF85FF041, 32'hF80FF3E0, delivered in that order.
- Boundaries with out_ready=1:
  - LDUR imm=256, imm=-257 and B imm=2^25 -> each gives out_err=1, out_instr=0, err_count increments.
  - LDUR imm=-256 and B imm=-2^25 -> out_err=0.
- Backpressure: stream 6 requests with out_ready held 0 for 4 cycles -> in_ready drops after 2 accepts, out_instr stable throughout, all 6 words emerge in order, enc_count=6.
- Saturation and wrap: with ERR_W=2, send 5 illegal requests -> err_count stops at 3. With CNT_W=2, send 5 legal requests -> enc_count=1.
- Assert rst_n low for one cycle with 2 words in flight -> out_valid=0 immediately, both counters 0, next request encodes normally with latency 2.
- Randomized self-check: pass every output through the core's sign-extension logic and compare the recovered immediate to the sent immediate for legal cases.
